// File: rtl/sequence_pkg.sv
// Shared definitions for the sequence generator slice.
//  - state_t      : playback FSM states (IDLE, EMIT, DONE)
//  - DEFAULT_*    : default WIDTH / DEPTH / IDLE_VALUE used by the top level
package sequence_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH      = 4;
  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_IDLE_VALUE = 0;

endpackage : sequence_pkg

// File: rtl/seq_mem.sv
// Sequence memory: DEPTH x WIDTH register file.
//  clock    in   rising-edge clock
//  reset_n  in   asynchronous active-low clear of every entry
//  wr_en    in   write strobe (already qualified by the caller)
//  wr_addr  in   write address
//  wr_data  in   write data
//  rd_addr  in   read address
//  rd_data  out  combinational read of entry rd_addr
module seq_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] entries [DEPTH];

  // One register per entry so that each is owned by exactly one process.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          entry_reg <= '0;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign rd_data = entries[rd_addr];

endmodule : seq_mem

// File: rtl/sequence_generator.sv
// Stimulus source: plays a programmed list of numbers onto `number`, one per
// clock, optionally repeated.
//  clock         in   rising-edge clock
//  reset_n       in   asynchronous active-low reset
//  wr_en         in   write sequence memory (ignored while emitting)
//  wr_addr       in   write address
//  wr_data       in   write data
//  seq_len       in   entries per pass, clamped to DEPTH, sampled at start
//  repeat_count  in   extra passes after the first, sampled at start
//  start         in   begin playback (IDLE only)
//  hold          in   downstream stall, freezes the stream while emitting
//  number        out  emitted number (IDLE_VALUE when not valid)
//  number_valid  out  number carries a sequence entry
//  busy          out  high while emitting
//  done          out  one-cycle pulse after the final entry
module sequence_generator
  import sequence_pkg::*;
#(
  parameter int              WIDTH      = DEFAULT_WIDTH,
  parameter int              DEPTH      = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] IDLE_VALUE = WIDTH'(DEFAULT_IDLE_VALUE),
  localparam int             AW         = $clog2(DEPTH),
  localparam int             LW         = AW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [LW-1:0]    seq_len,
  input  logic [3:0]       repeat_count,
  input  logic             start,
  input  logic             hold,
  output logic [WIDTH-1:0] number,
  output logic             number_valid,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [AW-1:0]    idx_reg, idx_next;
  logic [3:0]       pass_reg, pass_next;
  logic [3:0]       passes_reg, passes_next;
  logic [LW-1:0]    len_reg, len_next;
  logic [WIDTH-1:0] number_reg, number_next;
  logic             valid_reg, valid_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             mem_wr_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [LW-1:0]    seq_len_clamped;
  logic             last_entry;
  logic             bypass_hit;

  // Memory is write-protected for the whole of playback.
  assign mem_wr_en = wr_en && (state_reg != EMIT);

  seq_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign seq_len_clamped = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
  assign last_entry      = ({1'b0, idx_reg} == (len_reg - LW'(1)));

  // Address of the entry the next edge loads into number_reg: the following
  // index mid-pass, entry 0 on start or on a pass wrap.
  assign rd_addr = ((state_reg == EMIT) && !last_entry) ? (idx_reg + AW'(1)) : '0;

  // A write to entry 0 on the start edge has not landed in memory yet, so
  // forward it directly.
  assign bypass_hit = wr_en && (wr_addr == '0);

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    pass_next   = pass_reg;
    passes_next = passes_reg;
    len_next    = len_reg;
    number_next = number_reg;
    valid_next  = valid_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        number_next = IDLE_VALUE;
        valid_next  = 1'b0;
        busy_next   = 1'b0;
        if (start) begin
          len_next    = seq_len_clamped;
          passes_next = repeat_count;
          idx_next    = '0;
          pass_next   = '0;
          if (seq_len_clamped == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next  = EMIT;
            valid_next  = 1'b1;
            busy_next   = 1'b1;
            number_next = bypass_hit ? wr_data : rd_data;
          end
        end
      end

      EMIT: begin
        if (!hold) begin
          if (last_entry) begin
            if (pass_reg < passes_reg) begin
              idx_next    = '0;
              pass_next   = pass_reg + 4'd1;
              number_next = rd_data;
            end else begin
              state_next  = DONE;
              number_next = IDLE_VALUE;
              valid_next  = 1'b0;
              busy_next   = 1'b0;
              done_next   = 1'b1;
            end
          end else begin
            idx_next    = idx_reg + AW'(1);
            number_next = rd_data;
          end
        end
      end

      DONE: begin
        state_next  = IDLE;
        idx_next    = '0;
        pass_next   = '0;
        number_next = IDLE_VALUE;
        valid_next  = 1'b0;
        busy_next   = 1'b0;
      end

      default: begin
        state_next  = IDLE;
        number_next = IDLE_VALUE;
        valid_next  = 1'b0;
        busy_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      pass_reg   <= '0;
      passes_reg <= '0;
      len_reg    <= '0;
      number_reg <= IDLE_VALUE;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      pass_reg   <= pass_next;
      passes_reg <= passes_next;
      len_reg    <= len_next;
      number_reg <= number_next;
      valid_reg  <= valid_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign number       = number_reg;
  assign number_valid = valid_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule : sequence_generator

// File: tb/tb_sequence_generator.sv
module tb_sequence_generator;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int LW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [LW-1:0] seq_len;
  logic [3:0]    repeat_count;
  logic          start;
  logic          hold;
  logic [W-1:0]  number;
  logic          number_valid;
  logic          busy;
  logic          done;

  always #5 clock = ~clock;

  sequence_generator dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .seq_len      (seq_len),
    .repeat_count (repeat_count),
    .start        (start),
    .hold         (hold),
    .number       (number),
    .number_valid (number_valid),
    .busy         (busy),
    .done         (done)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the whole run is expanded into a list of numbers up
  // front; during playback only a position in that list is tracked.
  // m_mode: 0 idle, 1 emitting, 2 done cycle.
  logic [W-1:0] m_mem [D];
  int           m_mode;
  int           m_k;
  int           m_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_mode = 0;
    m_k    = 0;
    m_q.delete();
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_edge();
    int len;
    case (m_mode)
      0: begin
        if (wr_en) m_mem[wr_addr] = wr_data;
        if (start) begin
          len = (int'(seq_len) > D) ? D : int'(seq_len);
          m_q.delete();
          for (int p = 0; p <= int'(repeat_count); p++)
            for (int i = 0; i < len; i++) m_q.push_back(int'(m_mem[i]));
          $display("run start len=%0d passes=%0d expected_valid=%0d",
                   len, repeat_count, m_q.size());
          m_k    = 0;
          m_mode = (len == 0) ? 2 : 1;
        end
      end
      1: begin
        if (!hold) begin
          m_k++;
          if (m_k >= m_q.size()) m_mode = 2;
        end
      end
      default: begin
        if (wr_en) m_mem[wr_addr] = wr_data;
        m_mode = 0;
      end
    endcase
  endtask

  task automatic compare_outputs();
    int exp_num;
    exp_num = (m_mode == 1) ? m_q[m_k] : 0;
    check_val("number_valid", 32'(number_valid), 32'(m_mode == 1));
    check_val("number", 32'(number), 32'(exp_num));
    check_val("busy", 32'(busy), 32'(m_mode == 1));
    check_val("done", 32'(done), 32'(m_mode == 2));
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    compare_outputs();
  endtask

  task automatic write_entry(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = W'(d);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic run(input int len, input int rep, input int tail);
    seq_len      = LW'(len);
    repeat_count = 4'(rep);
    start        = 1'b1;
    step();
    start        = 1'b0;
    repeat (tail) step();
  endtask

  initial begin
    reset_n      = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    seq_len      = '0;
    repeat_count = '0;
    start        = 1'b0;
    hold         = 1'b0;
    model_reset();

    repeat (2) @(posedge clock);
    #1;
    compare_outputs();
    reset_n = 1'b1;

    // Program {1,0,9,4}, single pass.
    write_entry(0, 1);
    write_entry(1, 0);
    write_entry(2, 9);
    write_entry(3, 4);
    run(4, 0, 6);

    // Same list, one repeat, back-to-back.
    run(4, 1, 10);

    // Hold on cycles 2-3 of the run.
    seq_len = 4; repeat_count = 0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    hold = 1'b1;
    step();
    step();
    hold = 1'b0;
    repeat (6) step();

    // Zero length and clamped length.
    run(0, 0, 3);
    run(12, 0, 11);

    // Write and start during playback are ignored.
    seq_len = 4; repeat_count = 0; start = 1'b1;
    step();
    wr_en = 1'b1; wr_addr = 2; wr_data = 7;
    step();
    wr_en = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    run(4, 0, 6);

    // Write bypass on entry 0 at the start edge.
    wr_en = 1'b1; wr_addr = 0; wr_data = 5;
    seq_len = 4; repeat_count = 0; start = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    repeat (6) step();

    // Asynchronous reset in the middle of playback.
    seq_len = 4; repeat_count = 3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    @(posedge clock);
    #1;
    compare_outputs();
    reset_n = 1'b1;
    run(4, 0, 6);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      start        = ($urandom_range(0, 7) == 0);
      hold         = ($urandom_range(0, 3) == 0);
      wr_en        = ($urandom_range(0, 2) == 0);
      wr_addr      = AW'($urandom_range(0, D - 1));
      wr_data      = W'($urandom_range(0, 15));
      seq_len      = LW'($urandom_range(0, 15));
      repeat_count = 4'($urandom_range(0, 3));
      step();
    end
    start = 1'b0;
    hold  = 1'b0;
    wr_en = 1'b0;
    repeat (80) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sequence_generator
